// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared FSM state type and default beat geometry for the DRAM port arbiter
package dram_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WR_BURST, RD_WAIT} state_t;
  localparam int DEF_BEAT_W = 32;
  localparam int DEF_BEATS = 4;
  localparam int DEF_SLOG = $clog2(DEF_BEATS);
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr
//   req       : request vector
//   ptr       : highest-priority index this cycle
//   grant     : one-hot winner (zero when no request)
//   grant_idx : binary winner index
module rr_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);
  always_comb begin
    int idx;
    grant_idx = '0;
    // walk from farthest to nearest offset so the nearest requester overwrites last
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) grant_idx = IW'(idx);
    end
    grant = |req ? NREQ'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter: round-robin sharing of one block-DRAM port among NREQ requesters
//   req_*  : per-requester block read/write request; req_ready is a one-hot acceptance pulse
//   rd_*   : registered read-beat return, rd_valid one-hot to the transaction owner
//   mem_*  : DRAM port: read command (mem_en), write burst (mem_we), read-beat return
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ADDR_W = 32,
  parameter int BEAT_W = DEF_BEAT_W,
  parameter int BEATS = DEF_BEATS,
  localparam int SLOG = $clog2(BEATS),
  localparam int IW = $clog2(NREQ),
  localparam int BLK_W = BEATS * BEAT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*BLK_W-1:0]  req_wblock,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rd_valid,
  output logic [SLOG-1:0]        rd_strobe,
  output logic [BEAT_W-1:0]      rd_data,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_en,
  output logic                   mem_we,
  output logic [SLOG-1:0]        mem_wstrobe,
  output logic [BEAT_W-1:0]      mem_wdata,
  input  logic [SLOG-1:0]        mem_rstrobe,
  input  logic [BEAT_W-1:0]      mem_rdata,
  input  logic                   mem_rvalid,
  input  logic                   mem_accR,
  input  logic                   mem_accW
);
  state_t state_q, state_d;
  logic [IW-1:0] ptr_q, own_q, gidx;
  logic [NREQ-1:0] grant;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BLK_W-1:0] wblk_q;
  logic [SLOG-1:0] beat_q;
  logic [NREQ-1:0] rd_valid_q;
  logic [SLOG-1:0] rd_strobe_q;
  logic [BEAT_W-1:0] rd_data_q;
  logic accept, wr_go, rd_go, rd_beat, rd_last;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req(req_valid),
    .ptr(ptr_q),
    .grant(grant),
    .grant_idx(gidx)
  );

  assign accept = !reset && state_q == IDLE && |req_valid;
  assign wr_go = state_q == ISSUE && we_q && mem_accW;
  assign rd_go = state_q == ISSUE && !we_q && mem_accR;
  assign rd_beat = state_q == RD_WAIT && mem_rvalid;
  assign rd_last = rd_beat && mem_rstrobe == SLOG'(BEATS - 1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = |req_valid ? ISSUE : IDLE;
      ISSUE:    state_d = wr_go ? WR_BURST : rd_go ? RD_WAIT : ISSUE;
      WR_BURST: state_d = beat_q == SLOG'(BEATS - 1) ? IDLE : WR_BURST;
      RD_WAIT:  state_d = rd_last ? IDLE : RD_WAIT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
      own_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wblk_q <= '0;
      beat_q <= '0;
      rd_valid_q <= '0;
      rd_strobe_q <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        own_q <= gidx;
        we_q <= req_we[gidx];
        addr_q <= req_addr[gidx*ADDR_W +: ADDR_W];
        wblk_q <= req_wblock[gidx*BLK_W +: BLK_W];
        ptr_q <= gidx == IW'(NREQ - 1) ? '0 : gidx + 1'b1;
      end
      // beat 0 goes out from ISSUE, so the burst counter starts at 1
      beat_q <= wr_go ? SLOG'(1) : beat_q + SLOG'(state_q == WR_BURST);
      rd_valid_q <= rd_beat ? NREQ'(1) << own_q : '0;
      if (rd_beat) begin
        rd_strobe_q <= mem_rstrobe;
        rd_data_q <= mem_rdata;
      end
    end
  end

  // combinational DRAM-side outputs are forced low while reset is asserted
  assign req_ready = accept ? grant : '0;
  assign mem_en = !reset && rd_go;
  assign mem_we = !reset && (wr_go || state_q == WR_BURST);
  assign mem_wstrobe = mem_we && state_q == WR_BURST ? beat_q : '0;
  assign mem_wdata = mem_we ? wblk_q[mem_wstrobe*BEAT_W +: BEAT_W] : '0;
  assign mem_addr = !reset && state_q != IDLE ? addr_q : '0;
  assign rd_valid = rd_valid_q;
  assign rd_strobe = rd_strobe_q;
  assign rd_data = rd_data_q;
endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter: directed scoreboard bench for dram_port_arbiter
module tb_dram_port_arbiter;
  localparam int NREQ = 2, AW = 32, BW = 32, BEATS = 4, SLOG = 2;

  typedef struct {
    int k;
    int c;
    logic [31:0] a;
    int s;
    logic [31:0] d;
  } ev_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [NREQ-1:0] req_valid, req_we, req_ready, rd_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*BEATS*BW-1:0] req_wblock;
  logic [SLOG-1:0] rd_strobe, mem_wstrobe, mem_rstrobe;
  logic [BW-1:0] rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic mem_en, mem_we, mem_rvalid, mem_accR, mem_accW;
  int cyc = 0, n_chk = 0, n_fail = 0;
  ev_t q[$];

  dram_port_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .BEAT_W(BW), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wblock(req_wblock),
    .req_ready(req_ready), .rd_valid(rd_valid), .rd_strobe(rd_strobe), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_we(mem_we), .mem_wstrobe(mem_wstrobe),
    .mem_wdata(mem_wdata), .mem_rstrobe(mem_rstrobe), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_accR(mem_accR), .mem_accW(mem_accW)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    return k == 0 ? "grant" : k == 1 ? "rd_cmd" : k == 2 ? "wr_beat" : "rd_beat";
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input int c, input logic [31:0] a, input int s, input logic [31:0] d);
    q.push_back('{k, c, a, s, d});
  endtask

  task automatic ev(input int k, input logic [31:0] a, input int s, input logic [31:0] d);
    ev_t e;
    n_chk++;
    if (q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s at cycle %0d: got a=%h s=%0d d=%h, nothing expected", kname(k), cyc, a, s, d);
    end else begin
      e = q.pop_front();
      if (e.k != k || e.c != cyc || e.a !== a || e.s != s || e.d !== d) begin
        n_fail++;
        $display("FAIL %s: got %s cyc=%0d a=%h s=%0d d=%h want %s cyc=%0d a=%h s=%0d d=%h",
                 kname(e.k), kname(k), cyc, a, s, d, kname(e.k), e.c, e.a, e.s, e.d);
      end
    end
  endtask

  always @(negedge clk) begin
    if (req_ready != 0) ev(0, 32'(req_ready), 0, 0);
    if (mem_en) ev(1, mem_addr, 0, 0);
    if (mem_we) ev(2, mem_addr, int'(mem_wstrobe), mem_wdata);
    if (rd_valid != 0) ev(3, 32'(rd_valid), int'(rd_strobe), rd_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic we, input logic [31:0] a, input logic [127:0] b);
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*AW +: AW] = a;
    req_wblock[r*128 +: 128] = b;
  endtask

  task automatic rd_txn(input int r, input logic [31:0] a, input int stall, input logic [31:0] base);
    logic [31:0] oh;
    oh = 32'(1) << r;
    tick();
    set_req(r, 1'b0, a, '0);
    if (stall > 0) mem_accR = 1'b0;
    push(0, cyc, oh, 0, 0);
    tick();
    req_valid[r] = 1'b0;
    repeat (stall) tick();
    mem_accR = 1'b1;
    push(1, cyc, a, 0, 0);
    tick();
    for (int k = 0; k < BEATS; k++) begin
      tick();
      mem_rvalid = 1'b1;
      mem_rstrobe = SLOG'(k);
      mem_rdata = base + 32'(k);
      push(3, cyc + 1, oh, k, base + 32'(k));
    end
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic wr_txn(input int r, input logic [31:0] a, input int stall, input logic [127:0] b);
    tick();
    set_req(r, 1'b1, a, b);
    if (stall > 0) mem_accW = 1'b0;
    push(0, cyc, 32'(1) << r, 0, 0);
    tick();
    req_valid[r] = 1'b0;
    repeat (stall) tick();
    mem_accW = 1'b1;
    for (int k = 0; k < BEATS; k++) push(2, cyc + k, a, k, b[k*32 +: 32]);
    repeat (BEATS) tick();
  endtask

  initial begin
    int c;
    logic [127:0] blk_a, blk_b, blk_c;
    blk_a = {32'h44, 32'h33, 32'h22, 32'h11};
    blk_b = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    blk_c = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    req_valid = '0; req_we = '0; req_addr = '0; req_wblock = '0;
    mem_rstrobe = '0; mem_rdata = '0; mem_rvalid = 1'b0; mem_accR = 1'b1; mem_accW = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 0);
    chk("reset rd_valid", 32'(rd_valid), 0);
    chk("reset rd_strobe", 32'(rd_strobe), 0);
    chk("reset rd_data", rd_data, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_en", 32'(mem_en), 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset mem_wstrobe", 32'(mem_wstrobe), 0);
    chk("reset mem_wdata", mem_wdata, 0);
    tick();
    reset = 1'b0;
    rd_txn(0, 32'h8000, 0, 32'hA0);
    wr_txn(1, 32'h9000, 0, blk_a);
    // stray beat in IDLE must not reach rd_valid
    tick();
    mem_rvalid = 1'b1; mem_rstrobe = 2'd3; mem_rdata = 32'hDEAD;
    tick();
    mem_rvalid = 1'b0;
    wr_txn(1, 32'h9100, 7, blk_b);
    rd_txn(0, 32'h8100, 5, 32'hB0);
    // req0 raised during req1's burst waits for IDLE
    tick();
    c = cyc;
    set_req(1, 1'b1, 32'h9200, blk_c);
    push(0, c, 32'h2, 0, 0);
    tick();
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, 32'h8300, blk_a);
    for (int k = 0; k < BEATS; k++) push(2, c + 1 + k, 32'h9200, k, blk_c[k*32 +: 32]);
    push(0, c + 5, 32'h1, 0, 0);
    for (int k = 0; k < BEATS; k++) push(2, c + 6 + k, 32'h8300, k, blk_a[k*32 +: 32]);
    repeat (5) tick();
    req_valid = '0;
    repeat (4) tick();
    // both requesters valid from reset: grants 0, 1, 0
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    c = cyc;
    set_req(0, 1'b1, 32'h8400, blk_b);
    set_req(1, 1'b1, 32'h9400, blk_c);
    push(0, c, 32'h1, 0, 0);
    for (int k = 0; k < BEATS; k++) push(2, c + 1 + k, 32'h8400, k, blk_b[k*32 +: 32]);
    push(0, c + 5, 32'h2, 0, 0);
    for (int k = 0; k < BEATS; k++) push(2, c + 6 + k, 32'h9400, k, blk_c[k*32 +: 32]);
    push(0, c + 10, 32'h1, 0, 0);
    for (int k = 0; k < BEATS; k++) push(2, c + 11 + k, 32'h8400, k, blk_b[k*32 +: 32]);
    repeat (11) tick();
    req_valid = '0;
    repeat (4) tick();
    // reset after two of four read beats
    tick();
    c = cyc;
    set_req(0, 1'b0, 32'h8200, '0);
    push(0, c, 32'h1, 0, 0);
    tick();
    req_valid = '0;
    push(1, c + 1, 32'h8200, 0, 0);
    tick();
    tick();
    mem_rvalid = 1'b1; mem_rstrobe = 2'd0; mem_rdata = 32'hC0;
    push(3, c + 4, 32'h1, 0, 32'hC0);
    tick();
    mem_rstrobe = 2'd1; mem_rdata = 32'hC1;
    push(3, c + 5, 32'h1, 1, 32'hC1);
    tick();
    reset = 1'b1;
    mem_rstrobe = 2'd2; mem_rdata = 32'hC2;
    tick();
    reset = 1'b0;
    mem_rstrobe = 2'd3; mem_rdata = 32'hC3;
    @(negedge clk);
    chk("midreset req_ready", 32'(req_ready), 0);
    chk("midreset rd_valid", 32'(rd_valid), 0);
    chk("midreset rd_strobe", 32'(rd_strobe), 0);
    chk("midreset rd_data", rd_data, 0);
    chk("midreset mem_addr", mem_addr, 0);
    chk("midreset mem_en", 32'(mem_en), 0);
    tick();
    mem_rvalid = 1'b0;
    // pointer back at 0: req0 wins over req1
    tick();
    c = cyc;
    set_req(0, 1'b1, 32'h8500, blk_c);
    set_req(1, 1'b1, 32'h9500, blk_a);
    push(0, c, 32'h1, 0, 0);
    for (int k = 0; k < BEATS; k++) push(2, c + 1 + k, 32'h8500, k, blk_c[k*32 +: 32]);
    tick();
    req_valid = '0;
    repeat (6) tick();
    @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: got %0d pending expected events want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
